// File: rtl/audio_channel_pkg.sv
// Shared types and constants for the audio byte serializer path.
// Anything sized in bytes derives from BYTE_W through bytes_per_sample().
package audio_channel_pkg;

  localparam int BYTE_W = 8;

  function automatic int bytes_per_sample(input int sample_w);
    return sample_w / BYTE_W;
  endfunction

  typedef enum logic {IDLE, SEND} ser_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Parameterised synchronous FIFO with push/pop, occupancy count and full/empty flags.
// Read data is the head entry, valid whenever empty is low.
module sample_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/audio_byte_serializer.sv
// Buffers PCM samples and streams each one as bytes, MSB byte first, with a
// byte_first marker on the leading byte so framing can realign after the channel.
module audio_byte_serializer
  import audio_channel_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [SAMPLE_W-1:0]               sample_in,
  input  logic                              sample_valid,
  output logic                              sample_ready,
  output logic [BYTE_W-1:0]                 byte_out,
  output logic                              byte_valid,
  output logic                              byte_first,
  input  logic                              byte_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int BYTES = bytes_per_sample(SAMPLE_W);
  localparam int IDX_W = $clog2(BYTES);

  ser_state_t          state_q, state_d;
  logic [SAMPLE_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                first_q, first_d;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0] fifo_rdata;
  logic                handshake, last_byte;

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (sample_in),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Readiness looks only at the registered count; a same-cycle pop never frees a slot.
  assign sample_ready = !reset && !fifo_full;
  assign fifo_push    = sample_valid && sample_ready;

  assign handshake = valid_q && byte_ready;
  assign last_byte = (idx_q == IDX_W'(BYTES - 1));

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    first_d  = first_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rdata;
          idx_d    = '0;
          first_d  = 1'b1;
          valid_d  = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          if (!last_byte) begin
            shreg_d = shreg_q << BYTE_W;
            idx_d   = idx_q + IDX_W'(1);
            first_d = 1'b0;
          end else if (!fifo_empty) begin
            // Chain straight into the next sample so the byte stream has no bubble.
            fifo_pop = 1'b1;
            shreg_d  = fifo_rdata;
            idx_d    = '0;
            first_d  = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      first_q <= first_d;
    end
  end

  // The top of the shift register is the outgoing byte; it simply holds while idle.
  assign byte_out   = shreg_q[SAMPLE_W-1 -: BYTE_W];
  assign byte_valid = valid_q;
  assign byte_first = first_q;

endmodule

// File: tb/tb_audio_byte_serializer.sv
// Self-checking bench for audio_byte_serializer: a byte-queue reference model
// is filled from accepted samples and drained by observed byte handshakes.
module tb_audio_byte_serializer;

  localparam int SW    = 16;
  localparam int DEPTH = 4;
  localparam int BYTES = SW / 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] sample_in;
  logic          sample_valid;
  logic          sample_ready;
  logic [7:0]    byte_out;
  logic          byte_valid;
  logic          byte_first;
  logic          byte_ready;
  logic [LW-1:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int emitted = 0;
  int accepted = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;

  audio_byte_serializer #(
    .SAMPLE_W   (SW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .byte_first   (byte_first),
    .byte_ready   (byte_ready),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  // Monitor on the falling edge: what it sees is exactly what the next rising edge samples.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (fifo_level > LW'(DEPTH) || sample_ready !== (fifo_level != LW'(DEPTH))) begin
        errors++;
        $display("FAIL level_ready: level=%0d ready=%b (level must be 0..%0d, ready must equal level!=%0d)",
                 fifo_level, sample_ready, DEPTH, DEPTH);
      end
      if (byte_valid && byte_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: got first=%b byte=%h, expected no byte", byte_first, byte_out);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e[8]) emitted++;
          if ({byte_first, byte_out} !== mon_e) begin
            errors++;
            $display("FAIL stream: got first=%b byte=%h, expected first=%b byte=%h",
                     byte_first, byte_out, mon_e[8], mon_e[7:0]);
          end
        end
      end
      if (sample_valid && sample_ready) begin
        accepted++;
        for (int k = 0; k < BYTES; k++)
          exp_q.push_back({(k == 0), sample_in[SW-1-8*k -: 8]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || byte_valid) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || byte_valid) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d byte_valid=%b, expected 0 and 0", exp_q.size(), byte_valid);
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    sample_valid = 1'b1;
    sample_in    = SW'($urandom);
    byte_ready   = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if (byte_out !== 8'h00 || byte_valid !== 1'b0 || byte_first !== 1'b0 ||
          fifo_level !== '0 || sample_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: out=%h valid=%b first=%b level=%0d ready=%b, expected all 0",
                 byte_out, byte_valid, byte_first, fifo_level, sample_ready);
      end
    end
    reset        = 1'b0;
    sample_valid = 1'b0;
    step();
    checks++;
    if (fifo_level !== '0 || byte_valid !== 1'b0 || sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: level=%0d valid=%b ready=%b, expected 0 0 1",
               fifo_level, byte_valid, sample_ready);
    end
  endtask

  task automatic test_single();
    sample_in    = 16'hA55A;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    checks++;
    if (fifo_level !== LW'(1) || byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_n: level=%0d valid=%b, expected 1 0", fifo_level, byte_valid);
    end
    step();
    checks++;
    if (byte_valid !== 1'b1 || byte_first !== 1'b1 || byte_out !== 8'hA5 || fifo_level !== '0) begin
      errors++;
      $display("FAIL single_n1: valid=%b first=%b out=%h level=%0d, expected 1 1 a5 0",
               byte_valid, byte_first, byte_out, fifo_level);
    end
    step();
    checks++;
    if (byte_valid !== 1'b1 || byte_first !== 1'b0 || byte_out !== 8'h5A) begin
      errors++;
      $display("FAIL single_n2: valid=%b first=%b out=%h, expected 1 0 5a", byte_valid, byte_first, byte_out);
    end
    step();
    checks++;
    if (byte_valid !== 1'b0 || byte_out !== 8'h5A) begin
      errors++;
      $display("FAIL single_n3: valid=%b out=%h, expected 0 5a (held)", byte_valid, byte_out);
    end
  endtask

  task automatic test_back_to_back();
    int  i, n, gaps;
    bit  acc, saw_full, started;
    i = 1; n = 0; gaps = 0; saw_full = 0; started = 0;
    emitted    = 0;
    byte_ready = 1'b1;
    while (i <= 256 && n < 2000) begin
      sample_in    = SW'(i);
      sample_valid = 1'b1;
      acc          = sample_ready;
      step();
      n++;
      if (acc) i++;
      if (!sample_ready) saw_full = 1;
      if (byte_valid) started = 1;
      else if (started && exp_q.size() != 0) gaps++;
    end
    sample_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      step();
      n++;
      if (!byte_valid && exp_q.size() != 0) gaps++;
    end
    drain();
    checks++;
    if (i !== 257) begin
      errors++;
      $display("FAIL b2b_accepted: next=%0d, expected 257", i);
    end
    checks++;
    if (!saw_full) begin
      errors++;
      $display("FAIL b2b_backpressure: sample_ready never fell, expected it to fall at level %0d", DEPTH);
    end
    checks++;
    if (gaps != 0) begin
      errors++;
      $display("FAIL b2b_gaps: gaps=%0d, expected 0", gaps);
    end
    checks++;
    if (emitted != 256) begin
      errors++;
      $display("FAIL b2b_emitted: samples=%0d, expected 256", emitted);
    end
  endtask

  task automatic test_backpressure();
    byte_ready   = 1'b1;
    sample_in    = 16'h1234;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    checks++;
    if (byte_out !== 8'h12 || byte_first !== 1'b1 || byte_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_msb: out=%h first=%b valid=%b, expected 12 1 1", byte_out, byte_first, byte_valid);
    end
    step();
    byte_ready   = 1'b0;
    sample_valid = 1'b1;
    repeat (5) begin
      sample_in = SW'($urandom);
      step();
      checks++;
      if (byte_out !== 8'h34 || byte_valid !== 1'b1 || byte_first !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: out=%h valid=%b first=%b, expected 34 1 0", byte_out, byte_valid, byte_first);
      end
    end
    checks++;
    if (fifo_level !== LW'(DEPTH) || sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: level=%0d ready=%b, expected %0d 0", fifo_level, sample_ready, DEPTH);
    end
    sample_valid = 1'b0;
    byte_ready   = 1'b1;
    drain();
  endtask

  task automatic test_wrap();
    int n;
    n        = 0;
    emitted  = 0;
    accepted = 0;
    while (accepted < 1000 && n < 20000) begin
      sample_valid = ($urandom_range(0, 3) != 0);
      sample_in    = SW'($urandom);
      byte_ready   = ($urandom_range(0, 3) != 0);
      step();
      n++;
    end
    sample_valid = 1'b0;
    byte_ready   = 1'b1;
    drain();
    checks++;
    if (accepted != 1000 || emitted != 1000) begin
      errors++;
      $display("FAIL wrap_count: accepted=%0d emitted=%0d, expected 1000 1000", accepted, emitted);
    end
  endtask

  task automatic test_reset_mid();
    byte_ready   = 1'b1;
    sample_in    = 16'hBEEF;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    checks++;
    if (byte_out !== 8'hBE || byte_first !== 1'b1) begin
      errors++;
      $display("FAIL mid_msb: out=%h first=%b, expected be 1", byte_out, byte_first);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (byte_valid !== 1'b0 || fifo_level !== '0 || sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b level=%0d ready=%b, expected 0 0 0", byte_valid, fifo_level, sample_ready);
    end
    exp_q.delete();
    step();
    step();
    reset        = 1'b0;
    sample_in    = 16'hCAFE;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    checks++;
    if (byte_out !== 8'hCA || byte_first !== 1'b1 || byte_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_ca: out=%h first=%b valid=%b, expected ca 1 1", byte_out, byte_first, byte_valid);
    end
    step();
    checks++;
    if (byte_out !== 8'hFE || byte_first !== 1'b0 || byte_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_fe: out=%h first=%b valid=%b, expected fe 0 1", byte_out, byte_first, byte_valid);
    end
    step();
    checks++;
    if (byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_end: valid=%b, expected 0", byte_valid);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
